// File: rtl/perf_counter_ctrl_if.sv
// perf_counter_ctrl_if: 16-bit request/response memory bus with read/write strobes.
// Signals:
//   address     16  byte address
//   read        1   read request, held until resp
//   write       1   write request, held until resp
//   wdata       16  write data
//   byte_enable 2   byte enables
//   resp        1   completion pulse
//   rdata       16  read data, valid with resp
// Modports: master issues requests, slave answers them.
interface perf_counter_ctrl_if;
    logic [15:0] address;
    logic        read;
    logic        write;
    logic [15:0] wdata;
    logic [1:0]  byte_enable;
    logic        resp;
    logic [15:0] rdata;
    modport master (
        output address, read, write, wdata, byte_enable,
        input  resp, rdata
    );
    modport slave (
        input  address, read, write, wdata, byte_enable,
        output resp, rdata
    );
endinterface

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: routes CPU data accesses to the performance-counter bank or the D-cache.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   mem (slave)   CPU data-memory bus
//   dc (master)   D-cache bus, driven straight from mem for non-local addresses
//   ctr_address   byte address presented to the counter bank, 16'hFFFF when idle
//   ctr_clear     clear strobe for the counter at ctr_address
//   ctr_rdata     counter read data, combinational from ctr_address
//   count_enable  global counting gate, reset to 1
// Optional macro PERF_CLEAR_ALL_EN: a control write with wdata[1]=1 clears every counter.
module perf_counter_ctrl #(
    parameter int          NUM_COUNTERS = 12,
    parameter logic [15:0] CTRL_ADDR    = 16'hFFE6
) (
    input  logic                       clk,
    input  logic                       reset,
    perf_counter_ctrl_if.slave         mem,
    perf_counter_ctrl_if.master        dc,
    output logic [15:0]                ctr_address,
    output logic                       ctr_clear,
    input  logic [15:0]                ctr_rdata,
    output logic                       count_enable
);
    localparam logic [15:0] WIN_BASE = 16'(32'h10000 - 2 * NUM_COUNTERS);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLR_ALL} state_t;
    state_t      state, state_n;
    logic [15:0] addr_q, rdata_q;
    logic [1:0]  be_q;
    logic        write_q, win_q, ctl_q, ce_q;
    logic        win, ctl, hit, accept;
`ifdef PERF_CLEAR_ALL_EN
    localparam int CW = $clog2(NUM_COUNTERS);
    logic [CW-1:0] clr_idx;
    logic          clr_all_q;
`endif
    assign win    = mem.address >= WIN_BASE;
    assign ctl    = mem.address[15:1] == CTRL_ADDR[15:1];
    assign hit    = win | ctl;
    assign accept = state == IDLE && hit && (mem.read || mem.write);
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rdata_q      <= '0;
            count_enable <= 1'b1;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= mem.address;
                be_q    <= mem.byte_enable;
                write_q <= mem.write;
                win_q   <= win;
                ctl_q   <= ctl;
                ce_q    <= mem.wdata[0];
`ifdef PERF_CLEAR_ALL_EN
                clr_all_q <= mem.wdata[1];
`endif
            end
            if (state == ACCESS) begin
                rdata_q <= write_q ? '0 : win_q ? ctr_rdata : {15'b0, count_enable};
                if (write_q && ctl_q && be_q[0])
                    count_enable <= ce_q;
            end
`ifdef PERF_CLEAR_ALL_EN
            clr_idx <= state == CLR_ALL ? clr_idx + 1'b1 : '0;
`endif
        end
    end
    always_comb begin
        state_n        = state;
        ctr_address    = 16'hFFFF;
        ctr_clear      = 1'b0;
        mem.resp       = 1'b0;
        mem.rdata      = rdata_q;
        dc.address     = mem.address;
        dc.wdata       = mem.wdata;
        dc.byte_enable = mem.byte_enable;
        dc.read        = 1'b0;
        dc.write       = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    dc.read   = mem.read;
                    dc.write  = mem.write;
                    mem.resp  = dc.resp;
                    mem.rdata = dc.rdata;
                end
                state_n = accept ? ACCESS : IDLE;
            end
            ACCESS: begin
                ctr_address = addr_q;
                ctr_clear   = write_q && win_q && |be_q;
`ifdef PERF_CLEAR_ALL_EN
                state_n = write_q && ctl_q && be_q[0] && clr_all_q ? CLR_ALL : RESP;
`else
                state_n = RESP;
`endif
            end
            RESP: begin
                mem.resp = 1'b1;
                state_n  = IDLE;
            end
            default: begin
`ifdef PERF_CLEAR_ALL_EN
                // Walk the bank from the top word downward, one counter per cycle.
                ctr_address = 16'hFFFE - (16'(clr_idx) << 1);
                ctr_clear   = 1'b1;
                state_n     = clr_idx == CW'(NUM_COUNTERS - 1) ? RESP : CLR_ALL;
`else
                state_n = IDLE;
`endif
            end
        endcase
        // Reset suppresses any strobe or response from an access in flight.
        if (reset) begin
            ctr_clear = 1'b0;
            mem.resp  = 1'b0;
        end
    end
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb_perf_counter_ctrl: directed self-checking bench for perf_counter_ctrl.
module tb_perf_counter_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ctr_address;
    logic [15:0] ctr_rdata = 16'h0;
    logic        ctr_clear, count_enable;
    int          tests = 0, fails = 0;
    perf_counter_ctrl_if mem_bus();
    perf_counter_ctrl_if dc_bus();
    perf_counter_ctrl dut (
        .clk(clk),
        .reset(reset),
        .mem(mem_bus),
        .dc(dc_bus),
        .ctr_address(ctr_address),
        .ctr_clear(ctr_clear),
        .ctr_rdata(ctr_rdata),
        .count_enable(count_enable)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic req(input logic [15:0] a, input logic rd, input logic wr,
                       input logic [15:0] wd, input logic [1:0] be);
        @(posedge clk);
        #1;
        mem_bus.address     = a;
        mem_bus.read        = rd;
        mem_bus.write       = wr;
        mem_bus.wdata       = wd;
        mem_bus.byte_enable = be;
    endtask
    task automatic drop;
        @(posedge clk);
        #1;
        mem_bus.read  = 1'b0;
        mem_bus.write = 1'b0;
        dc_bus.resp   = 1'b0;
    endtask
    initial begin
        mem_bus.address = 16'h0; mem_bus.read = 1'b0; mem_bus.write = 1'b0;
        mem_bus.wdata = 16'h0; mem_bus.byte_enable = 2'b00;
        dc_bus.resp = 1'b0; dc_bus.rdata = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_resp", 16'(mem_bus.resp), 16'h0);
        check("rst_clear", 16'(ctr_clear), 16'h0);
        check("rst_ce", 16'(count_enable), 16'h1);
        check("rst_ctr_addr", ctr_address, 16'hFFFF);
        @(posedge clk);
        #1 reset = 1'b0;
        // Counter read at the top of the window
        req(16'hFFFE, 1, 0, 16'h0, 2'b11);
        ctr_rdata = 16'h1234;
        @(negedge clk);
        check("rd_N_dcread", 16'(dc_bus.read), 16'h0);
        check("rd_N_resp", 16'(mem_bus.resp), 16'h0);
        @(negedge clk);
        check("rd_N1_addr", ctr_address, 16'hFFFE);
        check("rd_N1_resp", 16'(mem_bus.resp), 16'h0);
        check("rd_N1_dcread", 16'(dc_bus.read), 16'h0);
        @(negedge clk);
        check("rd_N2_resp", 16'(mem_bus.resp), 16'h1);
        check("rd_N2_rdata", mem_bus.rdata, 16'h1234);
        check("rd_N2_addr", ctr_address, 16'hFFFF);
        drop();
        @(negedge clk);
        check("rd_after_resp", 16'(mem_bus.resp), 16'h0);
        // Odd-address window write clears one counter
        req(16'hFFF5, 0, 1, 16'hBEEF, 2'b11);
        @(negedge clk);
        check("wr_N_clear", 16'(ctr_clear), 16'h0);
        @(negedge clk);
        check("wr_N1_clear", 16'(ctr_clear), 16'h1);
        check("wr_N1_addr", ctr_address, 16'hFFF5);
        @(negedge clk);
        check("wr_N2_clear", 16'(ctr_clear), 16'h0);
        check("wr_N2_resp", 16'(mem_bus.resp), 16'h1);
        check("wr_N2_rdata", mem_bus.rdata, 16'h0000);
        drop();
        // D-cache pass-through read
        req(16'h0040, 1, 0, 16'h0, 2'b11);
        @(negedge clk);
        check("dc_read", 16'(dc_bus.read), 16'h1);
        check("dc_addr", dc_bus.address, 16'h0040);
        check("dc_noresp", 16'(mem_bus.resp), 16'h0);
        dc_bus.rdata = 16'hCAFE;
        dc_bus.resp  = 1'b1;
        #1;
        check("dc_resp", 16'(mem_bus.resp), 16'h1);
        check("dc_rdata", mem_bus.rdata, 16'hCAFE);
        check("dc_clear", 16'(ctr_clear), 16'h0);
        drop();
        // Word just below the control register goes to the D-cache
        req(16'hFFE4, 0, 1, 16'h5555, 2'b11);
        @(negedge clk);
        check("ffe4_dcwrite", 16'(dc_bus.write), 16'h1);
        check("ffe4_dcaddr", dc_bus.address, 16'hFFE4);
        check("ffe4_wdata", dc_bus.wdata, 16'h5555);
        drop();
        // Control register: disable counting
        req(16'hFFE6, 0, 1, 16'h0000, 2'b01);
        @(negedge clk);
        check("ctl_N_dcwrite", 16'(dc_bus.write), 16'h0);
        @(negedge clk);
        check("ctl_N1_ce", 16'(count_enable), 16'h1);
        check("ctl_N1_clear", 16'(ctr_clear), 16'h0);
        @(negedge clk);
        check("ctl_N2_ce", 16'(count_enable), 16'h0);
        check("ctl_N2_resp", 16'(mem_bus.resp), 16'h1);
        drop();
        // Read control register at its odd byte address
        req(16'hFFE7, 1, 0, 16'h0, 2'b11);
        repeat (3) @(negedge clk);
        check("ctl_rd0_resp", 16'(mem_bus.resp), 16'h1);
        check("ctl_rd0_rdata", mem_bus.rdata, 16'h0000);
        drop();
        // Upper byte only: no change
        req(16'hFFE6, 0, 1, 16'h0001, 2'b10);
        repeat (3) @(negedge clk);
        check("ctl_be10_resp", 16'(mem_bus.resp), 16'h1);
        check("ctl_be10_ce", 16'(count_enable), 16'h0);
        drop();
        // Re-enable counting and read it back
        req(16'hFFE6, 0, 1, 16'h0001, 2'b01);
        repeat (3) @(negedge clk);
        check("ctl_en_ce", 16'(count_enable), 16'h1);
        drop();
        req(16'hFFE6, 1, 0, 16'h0, 2'b11);
        repeat (3) @(negedge clk);
        check("ctl_rd1_rdata", mem_bus.rdata, 16'h0001);
        drop();
        // Disable again so reset recovery of count_enable is visible
        req(16'hFFE6, 0, 1, 16'h0000, 2'b01);
        repeat (3) @(negedge clk);
        check("ctl_dis_ce", 16'(count_enable), 16'h0);
        drop();
        // Reset during the ACCESS cycle of a window write
        req(16'hFFE8, 0, 1, 16'hFFFF, 2'b11);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_acc_clear", 16'(ctr_clear), 16'h0);
        check("rst_acc_resp", 16'(mem_bus.resp), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_bus.write = 1'b0;
        @(negedge clk);
        check("rst_acc_noresp", 16'(mem_bus.resp), 16'h0);
        check("rst_acc_ce", 16'(count_enable), 16'h1);
        check("rst_acc_idle_addr", ctr_address, 16'hFFFF);
        req(16'hFFE8, 1, 0, 16'h0, 2'b11);
        ctr_rdata = 16'h0055;
        repeat (2) @(negedge clk);
        check("post_rst_N1_resp", 16'(mem_bus.resp), 16'h0);
        @(negedge clk);
        check("post_rst_resp", 16'(mem_bus.resp), 16'h1);
        check("post_rst_rdata", mem_bus.rdata, 16'h0055);
        drop();
`ifdef PERF_CLEAR_ALL_EN
        // Clear-all sequence
        req(16'hFFE6, 0, 1, 16'h0003, 2'b01);
        repeat (2) @(negedge clk);
        check("ca_N1_clear", 16'(ctr_clear), 16'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("ca_clear", 16'(ctr_clear), 16'h1);
            check("ca_addr", ctr_address, 16'(16'hFFFE - 2 * i));
            check("ca_noresp", 16'(mem_bus.resp), 16'h0);
        end
        @(negedge clk);
        check("ca_resp", 16'(mem_bus.resp), 16'h1);
        check("ca_end_clear", 16'(ctr_clear), 16'h0);
        check("ca_ce", 16'(count_enable), 16'h1);
        drop();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
